candidate_collector: RTL and testbench
======================================

Name: candidate_collector

Overview:
Downstream of the I2LBS window-inspection stage. Captures each completed window inspection that ends in a face candidate, tags it with the resized-frame (x, y) of the window, and buffers it in a FIFO. Entries drain to the host/OS side over a valid/ready interface. Frame-end is delimited with a drain phase and a one-cycle frame_done pulse.

Parameters:
DATA_WIDTH_12, 12, coordinate width.
FIFO_DEPTH, 16, candidate FIFO entries; power of two.
FIFO_ADDR_WIDTH, 4, log2(FIFO_DEPTH).
COUNT_WIDTH, 8, width of the per-frame candidate/drop counters; saturating.

Ports:
clk  input  1  single clock, shared with the inspection stage.
reset  input  1  synchronous, active-high.
inspect_done  input  1  level from inspection stage; a rising edge marks one finished window.
candidate  input  1  window verdict; valid in the cycle the inspect_done rising edge is detected.
resize_x  input  DATA_WIDTH_12  resized-frame x of the inspected window.
resize_y  input  DATA_WIDTH_12  resized-frame y of the inspected window.
frame_end  input  1  one-cycle pulse: last window of the frame has been issued.
out_ready  input  1  consumer accepts the head entry.
o_out_valid  output  1  head entry valid (FIFO non-empty).
o_out_x  output  DATA_WIDTH_12  head entry x.
o_out_y  output  DATA_WIDTH_12  head entry y.
o_count  output  COUNT_WIDTH  candidates accepted this frame.
o_drop_count  output  COUNT_WIDTH  candidates dropped this frame.
o_overflow  output  1  sticky: at least one drop this frame.
o_full  output  1  FIFO full.
o_frame_done  output  1  one-cycle pulse when a frame has fully drained.

Behaviour:
- Reset: FIFO empty; state COLLECT; inspect_done_d=0; all outputs 0, except o_out_x/o_out_y = 0 and o_full = 0. Reset asserted mid-operation discards the FIFO contents and counters in that same cycle.
- Event detect: event = inspect_done & ~inspect_done_d, where inspect_done_d is registered. A held-high inspect_done produces exactly one event.
- Push request = event & candidate & (state == COLLECT). Data {resize_x, resize_y} is sampled in the event cycle.
- FIFO is first-word-fall-through:
  - o_out_valid = !empty; head data is valid whenever o_out_valid = 1.
  - Pop = o_out_valid & out_ready.
  - A push is visible on o_out_valid on the next cycle, so push-to-valid latency is 1.
- Full handling:
  - Push while full with no pop: entry dropped; o_drop_count increments (saturating); o_overflow is set.
  - Push and pop in the same cycle while full: both take effect; no drop.
  - Push and pop on empty: the push is accepted, the pop is not, since valid = 0.
- Counters: o_count increments on each accepted push. Both counters saturate at all-ones.
- States:
  - COLLECT: pushes allowed. frame_end moves to DRAIN. An event in the same cycle as frame_end is still pushed.
  - DRAIN: further events are ignored and not counted. When the FIFO is empty (checked after any pop this cycle), move to DONE.
  - DONE (1 cycle): o_frame_done = 1. Clear o_count, o_drop_count and o_overflow. Move to COLLECT.
- frame_end while in DRAIN or DONE: ignored.
- Pointer wrap: read/write pointers wrap modulo FIFO_DEPTH. Full and empty are distinguished by an extra MSB on each pointer.

Optional Feature:
- Macro: CANDIDATE_MERGE_EN.
- Defined: an accepted candidate whose resize_y equals the last pushed y and whose |resize_x − last_x| ≤ 1 is suppressed. It is not pushed and is counted in neither o_count nor o_drop_count.
  - The last-pushed register is cleared at reset and in DONE.
  - The comparison uses the last accepted entry, not the last suppressed one.
- Undefined: every candidate event is pushed. The last-pushed register and comparator are absent.

Decomposition:
- Package face_detection_pkg:
  - collector state enum (COLLECT, DRAIN, DONE);
  - DATA_WIDTH_12 constant;
  - a candidate entry struct {x, y}.
- One sub-module, candidate_fifo: parameterised FWFT FIFO with push/pop/full/empty.
- The FSM, edge detect, counters and merge logic stay in candidate_collector.

Test Plan:
- Single hit: inspect_done rises with candidate=1, x=5, y=7, out_ready=1 → o_out_valid high one cycle later with (5,7); o_count=1.
- Level hold and miss: inspect_done held high 10 cycles with candidate=1 → exactly 1 entry. A separate event with candidate=0 → no entry, o_count unchanged.
- Overflow: out_ready=0, 18 candidate events → o_full=1 after 16; o_drop_count=2; o_overflow=1. Then push+pop in the same cycle while full → no extra drop.
- Frame end: 3 entries queued, then frame_end, then out_ready=1 → 3 pops in order. o_frame_done pulses the cycle after the last pop; counters read 0 afterwards. An event during DRAIN is ignored.
- Reset mid-frame: 5 entries queued, assert reset for 1 cycle → o_out_valid=0, o_count=0, state COLLECT; the next event lands as entry 1.
- CANDIDATE_MERGE_EN: events (4,2), (5,2), (7,2), (7,3) → with macro: entries (4,2), (7,2), (7,3); without macro: all 4 entries.

Source files
------------

// File: rtl/face_detection_pkg.sv
// Shared types for the face-detection candidate path: collector FSM states,
// the coordinate width and the packed candidate entry.
package face_detection_pkg;

    localparam int DATA_WIDTH_12 = 12;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        DRAIN   = 2'd1,
        DONE    = 2'd2
    } collector_state_t;

    typedef struct packed {
        logic [DATA_WIDTH_12-1:0] x;
        logic [DATA_WIDTH_12-1:0] y;
    } cand_entry_t;

endpackage

// File: rtl/candidate_fifo.sv
// First-word-fall-through FIFO; pointers carry one extra MSB so that full and
// empty can be told apart. Head data reads as zero while empty.
module candidate_fifo #(
    parameter int DATA_W = 24,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_push,
    input  logic              i_pop,
    input  logic [DATA_W-1:0] i_data,
    output logic [DATA_W-1:0] o_data,
    output logic              o_full,
    output logic              o_empty,
    output logic [ADDR_W:0]   o_level
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [ADDR_W:0]   r_wr_ptr;
    logic [ADDR_W:0]   r_rd_ptr;
    logic              w_wr_en;
    logic              w_rd_en;

    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[ADDR_W] != r_rd_ptr[ADDR_W]) &&
                     (r_wr_ptr[ADDR_W-1:0] == r_rd_ptr[ADDR_W-1:0]);
    assign o_level = r_wr_ptr - r_rd_ptr;

    // A write into a full FIFO is allowed only when the head leaves this cycle.
    assign w_rd_en = i_pop & ~o_empty;
    assign w_wr_en = i_push & (~o_full | w_rd_en);
    assign o_data  = o_empty ? {DATA_W{1'b0}} : r_mem[r_rd_ptr[ADDR_W-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= {(ADDR_W+1){1'b0}};
            r_rd_ptr <= {(ADDR_W+1){1'b0}};
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + {{ADDR_W{1'b0}}, 1'b1};
            end
            if (w_rd_en) begin
                r_rd_ptr <= r_rd_ptr + {{ADDR_W{1'b0}}, 1'b1};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr[ADDR_W-1:0]] <= i_data;
        end
    end

endmodule

// File: rtl/candidate_collector.sv
// Collects face-candidate windows into a FWFT FIFO and drains them per frame.
// Optional feature macro: CANDIDATE_MERGE_EN (suppress near-duplicate neighbours).
module candidate_collector
    import face_detection_pkg::*;
#(
    parameter int FIFO_DEPTH      = 16,
    parameter int FIFO_ADDR_WIDTH = 4,
    parameter int COUNT_WIDTH     = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     inspect_done,
    input  logic                     candidate,
    input  logic [DATA_WIDTH_12-1:0] resize_x,
    input  logic [DATA_WIDTH_12-1:0] resize_y,
    input  logic                     frame_end,
    input  logic                     out_ready,
    output logic                     o_out_valid,
    output logic [DATA_WIDTH_12-1:0] o_out_x,
    output logic [DATA_WIDTH_12-1:0] o_out_y,
    output logic [COUNT_WIDTH-1:0]   o_count,
    output logic [COUNT_WIDTH-1:0]   o_drop_count,
    output logic                     o_overflow,
    output logic                     o_full,
    output logic                     o_frame_done
);

    function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] v);
        if (v == {COUNT_WIDTH{1'b1}}) begin
            sat_inc = v;
        end else begin
            sat_inc = v + {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
        end
    endfunction

    collector_state_t        r_state;
    collector_state_t        w_state_next;
    logic                    r_inspect_done_d;
    logic [COUNT_WIDTH-1:0]  r_count;
    logic [COUNT_WIDTH-1:0]  r_drop_count;
    logic                    r_overflow;
    logic                    w_event;
    logic                    w_push_req;
    logic                    w_suppress;
    logic                    w_push_ok;
    logic                    w_drop;
    logic                    w_pop;
    logic                    w_fifo_full;
    logic                    w_fifo_empty;
    logic                    w_drain_empty;
    logic [FIFO_ADDR_WIDTH:0] w_level;
    cand_entry_t             w_in_entry;
    cand_entry_t             w_head;

    assign w_event    = inspect_done & ~r_inspect_done_d;
    assign w_push_req = w_event & candidate & (r_state == COLLECT);
    assign w_pop      = ~w_fifo_empty & out_ready;
    assign w_in_entry = '{x: resize_x, y: resize_y};

`ifdef CANDIDATE_MERGE_EN
    logic                     r_last_valid;
    logic [DATA_WIDTH_12-1:0] r_last_x;
    logic [DATA_WIDTH_12-1:0] r_last_y;
    logic [DATA_WIDTH_12-1:0] w_dx;

    assign w_dx = (resize_x >= r_last_x) ? (resize_x - r_last_x) : (r_last_x - resize_x);
    assign w_suppress = w_push_req & r_last_valid & (resize_y == r_last_y) &
                        (w_dx <= {{(DATA_WIDTH_12-1){1'b0}}, 1'b1});

    // Remember the last entry that actually entered the FIFO.
    always_ff @(posedge clk) begin
        if (reset || (r_state == DONE)) begin
            r_last_valid <= 1'b0;
            r_last_x     <= {DATA_WIDTH_12{1'b0}};
            r_last_y     <= {DATA_WIDTH_12{1'b0}};
        end else if (w_push_ok) begin
            r_last_valid <= 1'b1;
            r_last_x     <= resize_x;
            r_last_y     <= resize_y;
        end
    end
`else
    assign w_suppress = 1'b0;
`endif

    assign w_push_ok = w_push_req & ~w_suppress & (~w_fifo_full | w_pop);
    assign w_drop    = w_push_req & ~w_suppress & w_fifo_full & ~w_pop;

    // No pushes can land in DRAIN, so "empty after this cycle's pop" needs only the level.
    assign w_drain_empty = (w_level == {(FIFO_ADDR_WIDTH+1){1'b0}}) ||
                           (w_pop && (w_level == {{FIFO_ADDR_WIDTH{1'b0}}, 1'b1}));

    candidate_fifo #(
        .DATA_W ($bits(cand_entry_t)),
        .DEPTH  (FIFO_DEPTH),
        .ADDR_W (FIFO_ADDR_WIDTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push_req & ~w_suppress),
        .i_pop   (w_pop),
        .i_data  (w_in_entry),
        .o_data  (w_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_level (w_level)
    );

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            COLLECT: begin
                if (frame_end) begin
                    w_state_next = DRAIN;
                end else begin
                    w_state_next = COLLECT;
                end
            end
            DRAIN: begin
                if (w_drain_empty) begin
                    w_state_next = DONE;
                end else begin
                    w_state_next = DRAIN;
                end
            end
            DONE:    w_state_next = COLLECT;
            default: w_state_next = COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state          <= COLLECT;
            r_inspect_done_d <= 1'b0;
        end else begin
            r_state          <= w_state_next;
            r_inspect_done_d <= inspect_done;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || (r_state == DONE)) begin
            r_count      <= {COUNT_WIDTH{1'b0}};
            r_drop_count <= {COUNT_WIDTH{1'b0}};
            r_overflow   <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_count <= sat_inc(r_count);
            end
            if (w_drop) begin
                r_drop_count <= sat_inc(r_drop_count);
                r_overflow   <= 1'b1;
            end
        end
    end

    assign o_out_valid  = ~w_fifo_empty;
    assign o_out_x      = w_head.x;
    assign o_out_y      = w_head.y;
    assign o_count      = r_count;
    assign o_drop_count = r_drop_count;
    assign o_overflow   = r_overflow;
    assign o_full       = w_fifo_full;
    assign o_frame_done = (r_state == DONE);

endmodule

// File: tb/tb_candidate_collector.sv
// Directed bench for candidate_collector: stimulus pushes expected entries into
// a queue, a negedge monitor pops and compares every accepted head entry.
module tb_candidate_collector;

    logic        clk;
    logic        reset;
    logic        inspect_done;
    logic        candidate;
    logic [11:0] resize_x;
    logic [11:0] resize_y;
    logic        frame_end;
    logic        out_ready;
    logic        o_out_valid;
    logic [11:0] o_out_x;
    logic [11:0] o_out_y;
    logic [7:0]  o_count;
    logic [7:0]  o_drop_count;
    logic        o_overflow;
    logic        o_full;
    logic        o_frame_done;

    int          n_vec;
    int          n_bad;
    logic [23:0] exp_q [$];
    logic [23:0] mon_e;

    candidate_collector dut (
        .clk          (clk),
        .reset        (reset),
        .inspect_done (inspect_done),
        .candidate    (candidate),
        .resize_x     (resize_x),
        .resize_y     (resize_y),
        .frame_end    (frame_end),
        .out_ready    (out_ready),
        .o_out_valid  (o_out_valid),
        .o_out_x      (o_out_x),
        .o_out_y      (o_out_y),
        .o_count      (o_count),
        .o_drop_count (o_drop_count),
        .o_overflow   (o_overflow),
        .o_full       (o_full),
        .o_frame_done (o_frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One window inspection: rising inspect_done for one cycle, then low.
    task automatic ev(input logic c, input logic [11:0] x, input logic [11:0] y, input bit expect_push);
        inspect_done = 1'b1;
        candidate    = c;
        resize_x     = x;
        resize_y     = y;
        if (expect_push) exp_q.push_back({x, y});
        tick();
        inspect_done = 1'b0;
        candidate    = 1'b0;
        tick();
    endtask

    // Scoreboard monitor: a head entry accepted at the coming edge must match the queue.
    always @(negedge clk) begin
        if (!reset && o_out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL pop_unexpected: got (%0d,%0d), expected no entry", o_out_x, o_out_y);
            end else begin
                mon_e = exp_q.pop_front();
                chk("pop_x", int'(o_out_x), int'(mon_e[23:12]));
                chk("pop_y", int'(o_out_y), int'(mon_e[11:0]));
            end
        end
    end

    initial begin
        n_vec        = 0;
        n_bad        = 0;
        reset        = 1'b1;
        inspect_done = 1'b0;
        candidate    = 1'b0;
        resize_x     = 12'd0;
        resize_y     = 12'd0;
        frame_end    = 1'b0;
        out_ready    = 1'b0;
        tick();
        tick();
        chk("rst_valid", int'(o_out_valid), 0);
        chk("rst_count", int'(o_count), 0);
        chk("rst_drop", int'(o_drop_count), 0);
        chk("rst_ovf", int'(o_overflow), 0);
        chk("rst_full", int'(o_full), 0);
        chk("rst_done", int'(o_frame_done), 0);
        chk("rst_x", int'(o_out_x), 0);
        reset = 1'b0;
        tick();

        // Single hit, 1-cycle push-to-valid latency
        out_ready    = 1'b1;
        inspect_done = 1'b1;
        candidate    = 1'b1;
        resize_x     = 12'd5;
        resize_y     = 12'd7;
        exp_q.push_back({12'd5, 12'd7});
        chk("hit_valid_before", int'(o_out_valid), 0);
        tick();
        chk("hit_valid_after", int'(o_out_valid), 1);
        chk("hit_count", int'(o_count), 1);
        inspect_done = 1'b0;
        candidate    = 1'b0;
        tick();

        // Held-high level gives exactly one entry; a miss gives none
        inspect_done = 1'b1;
        candidate    = 1'b1;
        resize_x     = 12'd9;
        resize_y     = 12'd3;
        exp_q.push_back({12'd9, 12'd3});
        for (int i = 0; i < 10; i++) tick();
        chk("hold_count", int'(o_count), 2);
        inspect_done = 1'b0;
        candidate    = 1'b0;
        tick();
        ev(1'b0, 12'd1, 12'd1, 1'b0);
        chk("miss_count", int'(o_count), 2);
        chk("miss_valid", int'(o_out_valid), 0);

        // Overflow: 18 events into a stalled 16-deep FIFO
        out_ready = 1'b0;
        for (int i = 0; i < 18; i++) begin
            ev(1'b1, 12'(100 + i), 12'(i), (i < 16));
            if (i == 14) chk("full_at_15", int'(o_full), 0);
            if (i == 15) chk("full_at_16", int'(o_full), 1);
        end
        chk("ovf_drop", int'(o_drop_count), 2);
        chk("ovf_flag", int'(o_overflow), 1);
        chk("ovf_count", int'(o_count), 18);
        // Push and pop together while full: both happen, no drop
        out_ready    = 1'b1;
        inspect_done = 1'b1;
        candidate    = 1'b1;
        resize_x     = 12'd200;
        resize_y     = 12'd50;
        exp_q.push_back({12'd200, 12'd50});
        tick();
        out_ready    = 1'b0;
        inspect_done = 1'b0;
        candidate    = 1'b0;
        chk("pp_drop", int'(o_drop_count), 2);
        chk("pp_count", int'(o_count), 19);
        chk("pp_full", int'(o_full), 1);
        out_ready = 1'b1;
        for (int i = 0; i < 18; i++) tick();
        chk("ovf_drained", int'(o_out_valid), 0);

        // Frame end with 3 queued entries and an ignored event during DRAIN
        out_ready = 1'b0;
        ev(1'b1, 12'd10, 12'd1, 1'b1);
        ev(1'b1, 12'd11, 12'd1, 1'b1);
        ev(1'b1, 12'd12, 12'd1, 1'b1);
        chk("fe_count", int'(o_count), 22);
        frame_end = 1'b1;
        tick();
        frame_end = 1'b0;
        ev(1'b1, 12'd13, 12'd1, 1'b0);
        chk("drain_count", int'(o_count), 22);
        out_ready = 1'b1;
        tick();
        tick();
        chk("fd_early", int'(o_frame_done), 0);
        tick();
        chk("fd_pulse", int'(o_frame_done), 1);
        chk("fd_empty", int'(o_out_valid), 0);
        tick();
        chk("fd_end", int'(o_frame_done), 0);
        chk("fd_count_clr", int'(o_count), 0);
        chk("fd_drop_clr", int'(o_drop_count), 0);
        chk("fd_ovf_clr", int'(o_overflow), 0);

        // Reset mid-frame discards queued entries and counters
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) ev(1'b1, 12'(30 + i), 12'd4, 1'b1);
        chk("pre_rst_count", int'(o_count), 5);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_q.delete();
        chk("mid_rst_valid", int'(o_out_valid), 0);
        chk("mid_rst_count", int'(o_count), 0);
        ev(1'b1, 12'd40, 12'd5, 1'b1);
        chk("post_rst_count", int'(o_count), 1);
        out_ready = 1'b1;
        tick();
        tick();
        chk("post_rst_empty", int'(o_out_valid), 0);

        // Neighbour merge sequence
        out_ready = 1'b0;
        ev(1'b1, 12'd4, 12'd2, 1'b1);
`ifdef CANDIDATE_MERGE_EN
        ev(1'b1, 12'd5, 12'd2, 1'b0);
`else
        ev(1'b1, 12'd5, 12'd2, 1'b1);
`endif
        ev(1'b1, 12'd7, 12'd2, 1'b1);
        ev(1'b1, 12'd7, 12'd3, 1'b1);
`ifdef CANDIDATE_MERGE_EN
        chk("merge_count", int'(o_count), 4);
`else
        chk("merge_count", int'(o_count), 5);
`endif
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        chk("final_empty", int'(o_out_valid), 0);
        chk("queue_left", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
